// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multi-cycle MIPS controller.
// Optional feature macro: MC_BNE_EN (bne opcode support).
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPEEX  = 4'd6,
        S_RTYPEWB  = 4'd7,
        S_BRANCHEX = 4'd8,
        S_IMMEX    = 4'd9,
        S_IMMWB    = 4'd10,
        S_JEX      = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'b000,
        ALUOP_SUB   = 3'b001,
        ALUOP_FUNCT = 3'b010,
        ALUOP_AND   = 3'b011,
        ALUOP_OR    = 3'b100
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic is_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic aluop_t imm_aluop(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALUOP_AND;
            OP_ORI:  return ALUOP_OR;
            default: return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps the FSM's abstract ALU operation plus Funct to the ALU control code.
module mc_aludec
    import multicycle_controller_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctl
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        alu_ctl = ALUCTL_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctl = ALUCTL_SUB;
            ALUOP_AND: alu_ctl = ALUCTL_AND;
            ALUOP_OR:  alu_ctl = ALUCTL_OR;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctl = ALUCTL_ADD;
                    FN_SUB:  alu_ctl = ALUCTL_SUB;
                    FN_AND:  alu_ctl = ALUCTL_AND;
                    FN_OR:   alu_ctl = ALUCTL_OR;
                    FN_SLT:  alu_ctl = ALUCTL_SLT;
                    default: alu_ctl = ALUCTL_ADD;
                endcase
            end
            default:   alu_ctl = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multi-cycle MIPS datapath (shared memory, single ALU, IR).
// Optional feature macro: MC_BNE_EN enables the bne opcode.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic               AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic [1:0]         PCSrc,
    output logic               PCEn,
    output logic [2:0]         AluCtl,
    output logic               ExtOp,
    output logic [STATE_W-1:0] State
);

    state_t state, state_next;
    aluop_t alu_op;
    logic   mem_write_fsm, ir_write_fsm, reg_write_fsm;
    logic   pc_write, branch, taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = S_FETCH;
        IorD          = 1'b0;
        mem_write_fsm = 1'b0;
        ir_write_fsm  = 1'b0;
        RegDst        = 1'b0;
        MemToReg      = 1'b0;
        reg_write_fsm = 1'b0;
        AluSrcA       = 1'b0;
        AluSrcB       = 2'b00;
        PCSrc         = 2'b00;
        pc_write      = 1'b0;
        branch        = 1'b0;
        alu_op        = ALUOP_ADD;

        case (state)
            S_FETCH: begin
                AluSrcB      = 2'b01;
                ir_write_fsm = 1'b1;
                pc_write     = 1'b1;
                state_next   = S_DECODE;
            end
            S_DECODE: begin
                AluSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW:               state_next = S_MEMADR;
                    OP_RTYPE:                   state_next = S_RTYPEEX;
                    OP_BEQ:                     state_next = S_BRANCHEX;
`ifdef MC_BNE_EN
                    OP_BNE:                     state_next = S_BRANCHEX;
`endif
                    OP_ADDI, OP_ANDI, OP_ORI:   state_next = S_IMMEX;
                    OP_J:                       state_next = S_JEX;
                    default:                    state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                AluSrcA    = 1'b1;
                AluSrcB    = 2'b10;
                state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD       = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                MemToReg      = 1'b1;
                reg_write_fsm = 1'b1;
            end
            S_MEMWR: begin
                IorD          = 1'b1;
                mem_write_fsm = 1'b1;
            end
            S_RTYPEEX: begin
                AluSrcA    = 1'b1;
                alu_op     = ALUOP_FUNCT;
                state_next = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                RegDst        = 1'b1;
                reg_write_fsm = 1'b1;
            end
            S_BRANCHEX: begin
                AluSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_IMMEX: begin
                AluSrcA    = 1'b1;
                AluSrcB    = 2'b10;
                alu_op     = imm_aluop(Op);
                state_next = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write_fsm = 1'b1;
            end
            S_JEX: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    mc_aludec u_aludec (
        .alu_op  (alu_op),
        .funct   (Funct),
        .alu_ctl (AluCtl)
    );

`ifdef MC_BNE_EN
    assign taken = (Op == OP_BNE) ^ Zero;
`else
    assign taken = Zero;
`endif

    // Strobes are gated by reset so an abandoned instruction can never write.
    assign MemWrite = mem_write_fsm & ~reset;
    assign IRWrite  = ir_write_fsm & ~reset;
    assign RegWrite = reg_write_fsm & ~reset;
    assign PCEn     = (pc_write | (branch & taken)) & ~reset;
    assign ExtOp    = ~is_zero_ext(Op);
    assign State    = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller; honours MC_BNE_EN when defined.
module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] state;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic [2:0] alu_ctl;
        logic       ext_op;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  val;
        obs_t  mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic       IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, AluSrcA, PCEn, ExtOp;
    logic [1:0] AluSrcB, PCSrc;
    logic [2:0] AluCtl;
    logic [3:0] State;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    obs_t observed;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .Funct    (Funct),
        .Zero     (Zero),
        .IorD     (IorD),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemToReg (MemToReg),
        .RegWrite (RegWrite),
        .AluSrcA  (AluSrcA),
        .AluSrcB  (AluSrcB),
        .PCSrc    (PCSrc),
        .PCEn     (PCEn),
        .AluCtl   (AluCtl),
        .ExtOp    (ExtOp),
        .State    (State)
    );

    always #5 clk = ~clk;

    assign observed = {State, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
                       AluSrcA, AluSrcB, PCSrc, PCEn, AluCtl, ExtOp};

    function automatic logic [2:0] funct_ctl(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Reference outputs for a given state, written directly from the state table.
    function automatic obs_t model(input int st, input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input logic rst);
        obs_t o;
        logic tk;
`ifdef MC_BNE_EN
        tk = (op == 6'b000101) ? ~z : z;
`else
        tk = z;
`endif
        o        = '0;
        o.state  = 4'(st);
        o.ext_op = !((op == 6'b001100) || (op == 6'b001101));
        o.alu_ctl = 3'b010;
        case (st)
            0:  begin o.alu_src_b = 2'b01; o.ir_write = 1'b1; o.pc_en = 1'b1; end
            1:  o.alu_src_b = 2'b11;
            2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            3:  o.iord = 1'b1;
            4:  begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
            5:  begin o.iord = 1'b1; o.mem_write = 1'b1; end
            6:  begin o.alu_src_a = 1'b1; o.alu_ctl = funct_ctl(fn); end
            7:  begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
            8:  begin o.alu_src_a = 1'b1; o.alu_ctl = 3'b110; o.pc_src = 2'b01; o.pc_en = tk; end
            9:  begin
                    o.alu_src_a = 1'b1;
                    o.alu_src_b = 2'b10;
                    o.alu_ctl = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 : 3'b010;
                end
            10: o.reg_write = 1'b1;
            11: begin o.pc_src = 2'b10; o.pc_en = 1'b1; end
            default: ;
        endcase
        if (rst) begin
            o.mem_write = 1'b0;
            o.ir_write  = 1'b0;
            o.reg_write = 1'b0;
            o.pc_en     = 1'b0;
        end
        return o;
    endfunction

    task automatic push(input string tag, input int st);
        exp_t e;
        e.tag  = tag;
        e.val  = model(st, Op, Funct, Zero, reset);
        e.mask = '1;
        // AluCtl is only meaningful in states that name an ALU operation.
        if (st inside {3, 4, 5, 7, 10, 11}) e.mask.alu_ctl = 3'b000;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %h required an expectation", observed);
        end else begin
            e = sb.pop_front();
            assert ((observed & e.mask) === (e.val & e.mask)) else begin
                n_bad++;
                $error("FAIL %s: observed %h required %h", e.tag, observed & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic check_now(input string tag, input int st);
        push(tag, st);
        compare_front();
    endtask

    task automatic step(input string tag, input int st);
        push(tag, st);
        @(negedge clk);
        compare_front();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string name, input logic [5:0] op_v, input logic [5:0] fn_v,
                       input logic z_v, input int states[$]);
        Op    = op_v;
        Funct = fn_v;
        Zero  = z_v;
        foreach (states[i]) step($sformatf("%s_s%0d_%0d", name, i, states[i]), states[i]);
    endtask

    initial begin
        reset = 1'b1;
        Op    = 6'b100011;
        Funct = 6'b000000;
        Zero  = 1'b0;

        @(negedge clk);
        check_now("reset_fetch", 0);
        @(posedge clk);
        #1 reset = 1'b0;
        step("release_fetch", 0);

        // Asynchronous reset while in DECODE.
        reset = 1'b1;
        #1 check_now("reset_in_decode", 0);
        @(negedge clk);
        check_now("reset_held", 0);
        @(posedge clk);
        #1 reset = 1'b0;

        run("lw",  6'b100011, 6'b000000, 1'b0, '{0, 1, 2, 3, 4});
        run("sw",  6'b101011, 6'b000000, 1'b1, '{0, 1, 2, 5});
        run("add", 6'b000000, 6'b100000, 1'b0, '{0, 1, 6, 7});
        run("sub", 6'b000000, 6'b100010, 1'b1, '{0, 1, 6, 7});
        run("slt", 6'b000000, 6'b101010, 1'b0, '{0, 1, 6, 7});
        run("and", 6'b000000, 6'b100100, 1'b0, '{0, 1, 6, 7});
        run("or",  6'b000000, 6'b100101, 1'b0, '{0, 1, 6, 7});
        run("fnx", 6'b000000, 6'b111111, 1'b0, '{0, 1, 6, 7});
        run("beq_t",  6'b000100, 6'b100101, 1'b1, '{0, 1, 8});
        run("beq_nt", 6'b000100, 6'b100101, 1'b0, '{0, 1, 8});
        run("addi", 6'b001000, 6'b000000, 1'b0, '{0, 1, 9, 10});
        run("andi", 6'b001100, 6'b000000, 1'b0, '{0, 1, 9, 10});
        run("ori",  6'b001101, 6'b000000, 1'b0, '{0, 1, 9, 10});
        run("j",    6'b000010, 6'b000000, 1'b0, '{0, 1, 11});
        run("illegal", 6'b111111, 6'b000000, 1'b0, '{0, 1});
`ifdef MC_BNE_EN
        run("bne_t",  6'b000101, 6'b000000, 1'b0, '{0, 1, 8});
        run("bne_nt", 6'b000101, 6'b000000, 1'b1, '{0, 1, 8});
`else
        run("bne_illegal", 6'b000101, 6'b000000, 1'b0, '{0, 1});
`endif

        // Reset in MEMWB must suppress the register write of the abandoned lw.
        run("lw_abort", 6'b100011, 6'b000000, 1'b0, '{0, 1, 2, 3});
        reset = 1'b1;
        #1 check_now("reset_in_memwb", 0);
        @(posedge clk);
        #1 reset = 1'b0;
        run("sw_after", 6'b101011, 6'b000000, 1'b0, '{0, 1, 2, 5, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
